// File: rtl/multi_edge_detector.sv
// Multi-channel glitch-filtered edge detector with sticky event flags and irq.
// Each channel:
//   - filters its input with a stability counter;
//   - runs a 4-state Moore FSM that produces one-cycle rise/fall ticks;
//   - latches mode-qualified ticks into a write-1-to-clear flag.
// Optional macro MULTI_EDGE_DETECTOR_SYNC_EN inserts a SYNC_STAGES-deep
// synchroniser ahead of the filters. Without it, level must already be
// synchronous to clk.

module multi_edge_detector_ch #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_i,
  input  logic [1:0] mode_i,
  input  logic       evt_clr_i,
  output logic       level_filt_o,
  output logic       rise_tick_o,
  output logic       fall_tick_o,
  output logic       evt_flag_o,
  output logic       evt_nxt_o
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  typedef enum logic [1:0] {ZERO, RISE, ONE, FALL} state_e;

  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          evt_q, evt_d, qual;

  // Accept a new level only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s_i != stable_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) stable_d = s_i;
      else                                  cnt_d    = cnt_q + 1'b1;
    end
  end

  // Edge FSM: RISE/FALL last one cycle each and may chain directly
  // into each other, so no transition is lost when FILTER_CYCLES is 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ZERO:    if (stable_q) state_d = RISE;
      RISE:    state_d = stable_q ? ONE : FALL;
      ONE:     if (!stable_q) state_d = FALL;
      FALL:    state_d = stable_q ? RISE : ZERO;
      default: state_d = ZERO;
    endcase
  end

  assign rise_tick_o  = (state_q == RISE);
  assign fall_tick_o  = (state_q == FALL);
  assign level_filt_o = (state_q == RISE) || (state_q == ONE);

  // Flags latch the visible (registered) ticks; a set wins over a clear.
  assign qual  = (rise_tick_o & mode_i[0]) | (fall_tick_o & mode_i[1]);
  assign evt_d = qual | (evt_q & ~evt_clr_i);

  // Filter, FSM and flag state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= ZERO;
      evt_q    <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      evt_q    <= evt_d;
    end
  end

  assign evt_flag_o = evt_q;
  assign evt_nxt_o  = evt_d;
endmodule

module multi_edge_detector #(
  parameter int N_CH          = 4,
  parameter int FILTER_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   level,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   evt_clr,
  output logic [N_CH-1:0]   level_filt,
  output logic [N_CH-1:0]   rise_tick,
  output logic [N_CH-1:0]   fall_tick,
  output logic [N_CH-1:0]   evt_flag,
  output logic              irq
);
  if (N_CH < 1 || FILTER_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
    $error("multi_edge_detector: illegal parameter value");
  end

  logic [N_CH-1:0] s, evt_nxt;
  logic            irq_q;

`ifdef MULTI_EDGE_DETECTOR_SYNC_EN
  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;

  // Per-bit synchroniser chain, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], level};
  end

  assign s = sync_q[SYNC_STAGES-1];
`else
  assign s = level;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    multi_edge_detector_ch #(.FILTER_CYCLES(FILTER_CYCLES)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_i          (s[i]),
      .mode_i       (mode[2*i+1:2*i]),
      .evt_clr_i    (evt_clr[i]),
      .level_filt_o (level_filt[i]),
      .rise_tick_o  (rise_tick[i]),
      .fall_tick_o  (fall_tick[i]),
      .evt_flag_o   (evt_flag[i]),
      .evt_nxt_o    (evt_nxt[i])
    );
  end

  // irq tracks the flags' next state so it rises with the first flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= |evt_nxt;
  end

  assign irq = irq_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: two instances (FILTER_CYCLES=4 and =1)
// share stimulus and are checked every cycle against a behavioural model.
module tb_multi_edge_detector;
  localparam int N  = 4;
  localparam int F0 = 4;
  localparam int SS = 2;
`ifdef MULTI_EDGE_DETECTOR_SYNC_EN
  localparam int SDLY = SS;
`else
  localparam int SDLY = 0;
`endif
  localparam int LAT0 = F0 + 1 + SDLY;   // level change -> tick, instance 0
  localparam int LAT1 = 1 + 1 + SDLY;    // same for the FILTER_CYCLES=1 instance

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   level = '0, evt_clr = '0;
  logic [2*N-1:0] mode = '1;
  logic [1:0][N-1:0] lf, rt, ft, ef;
  logic [1:0]        irq;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(.N_CH(N), .FILTER_CYCLES(F0), .SYNC_STAGES(SS)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .evt_clr(evt_clr),
    .level_filt(lf[0]), .rise_tick(rt[0]), .fall_tick(ft[0]), .evt_flag(ef[0]), .irq(irq[0]));

  multi_edge_detector #(.N_CH(N), .FILTER_CYCLES(1), .SYNC_STAGES(SS)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .evt_clr(evt_clr),
    .level_filt(lf[1]), .rise_tick(rt[1]), .fall_tick(ft[1]), .evt_flag(ef[1]), .irq(irq[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Filtered level = last value that was seen for F samples in a row.
  // level_filt is that value one cycle later; ticks are its edges.
  // Flags latch the visible ticks under mode, clear is write-1, set wins.
  logic [1:0][N-1:0] m_stable = '0, m_lf = '0, m_rt = '0, m_ft = '0, m_ef = '0;
  logic [1:0]        m_irq = '0;
  int                m_run [2][N];
  logic [N-1:0]      hist [SS];
  logic [N-1:0]      m_s, m_me, m_mo, m_nf;
  int                m_f;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stable = '0; m_lf = '0; m_rt = '0; m_ft = '0; m_ef = '0; m_irq = '0;
      for (int k = 0; k < 2; k++) for (int i = 0; i < N; i++) m_run[k][i] = 0;
      for (int j = 0; j < SS; j++) hist[j] = '0;
    end else begin
      m_s = (SDLY > 0) ? hist[SS-1] : level;
      for (int j = SS - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = level;
      for (int i = 0; i < N; i++) begin
        m_me[i] = mode[2*i];
        m_mo[i] = mode[2*i+1];
      end
      for (int k = 0; k < 2; k++) begin
        m_f  = (k == 0) ? F0 : 1;
        m_nf = (m_rt[k] & m_me) | (m_ft[k] & m_mo) | (m_ef[k] & ~evt_clr);
        m_ef[k]  = m_nf;
        m_irq[k] = |m_nf;
        m_rt[k]  = m_stable[k] & ~m_lf[k];
        m_ft[k]  = ~m_stable[k] & m_lf[k];
        m_lf[k]  = m_stable[k];
        for (int i = 0; i < N; i++) begin
          if (m_s[i] != m_stable[k][i]) begin
            m_run[k][i]++;
            if (m_run[k][i] == m_f) begin
              m_stable[k][i] = m_s[i];
              m_run[k][i] = 0;
            end
          end else begin
            m_run[k][i] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("level_filt", k, 32'(lf[k]), 32'(m_lf[k]));
      chk("rise_tick",  k, 32'(rt[k]), 32'(m_rt[k]));
      chk("fall_tick",  k, 32'(ft[k]), 32'(m_ft[k]));
      chk("evt_flag",   k, 32'(ef[k]), 32'(m_ef[k]));
      chk("irq",        k, 32'(irq[k]), 32'(m_irq[k]));
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int   t_r, t_f, nr, nf, cnt;
  logic seen, both;

  initial begin
    cyc(3);
    reset_n = 1'b1;
    cyc(8);

    // Single rise on channel 0: tick exactly LAT0 cycles after the change.
    level[0] = 1'b1;
    cyc(LAT0 - 1);
    chk("rise0_early", 0, 32'(rt[0][0]), 0);
    cyc();
    chk("rise0_tick", 0, 32'(rt[0][0]), 1);
    chk("rise0_filt", 0, 32'(lf[0][0]), 1);
    cyc();
    chk("rise0_once", 0, 32'(rt[0][0]), 0);
    chk("rise0_flag", 0, 32'(ef[0][0]), 1);
    chk("rise0_irq",  0, 32'(irq[0]), 1);

    // 3-cycle glitch on channel 1 is rejected by the 4-cycle filter.
    level[1] = 1'b1;
    cyc(3);
    level[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      seen |= rt[0][1] | ft[0][1] | lf[0][1];
    end
    chk("glitch_rejected", 0, 32'(seen), 0);

    // 4-cycle pulse passes: rise then fall four cycles apart.
    level[1] = 1'b1;
    cyc(4);
    level[1] = 1'b0;
    t_r = -1; t_f = -1;
    for (int n = 0; n < 16; n++) begin
      cyc();
      if (rt[0][1]) t_r = n;
      if (ft[0][1]) t_f = n;
    end
    chk("pulse4_rise_seen", 0, 32'(t_r >= 0), 1);
    chk("pulse4_spacing", 0, 32'(t_f - t_r), 4);

    // Modes 00/01/10/11 on channels 0..3 with an 8-cycle pulse.
    level = '0;
    cyc(12);
    mode = 8'b11_10_01_00;
    evt_clr = '1;
    cyc();
    evt_clr = '0;
    level = '1;
    for (int n = 1; n <= 8 + LAT0 + 1; n++) begin
      cyc();
      if (n == 8) level = '0;
      if (n == LAT0 + 1) chk("mode_after_rise", 0, 32'(ef[0]), 32'h a);
    end
    chk("mode_after_fall", 0, 32'(ef[0]), 32'h e);

    // Set beats clear, then a lone clear drops the flag and irq.
    cyc(4);
    mode = '1;
    evt_clr = '1;
    cyc();
    evt_clr = '0;
    level[2] = 1'b1;
    cnt = 0;
    while (!rt[0][2] && cnt < 30) begin
      cyc();
      cnt++;
    end
    chk("clr_race_wait", 0, 32'(cnt < 30), 1);
    evt_clr = 4'b0100;
    cyc();
    chk("set_beats_clear", 0, 32'(ef[0][2]), 1);
    cyc();
    chk("clear_flag", 0, 32'(ef[0][2]), 0);
    chk("clear_irq",  0, 32'(irq[0]), 0);
    evt_clr = '0;

    // FILTER_CYCLES=1 instance: toggling every cycle gives a tick every cycle.
    level = '0;
    cyc(10);
    nr = 0; nf = 0; both = 1'b0;
    for (int n = 0; n < 6 + LAT1 + 4; n++) begin
      if (n < 6) level[0] = ~level[0];
      cyc();
      nr += int'(rt[1][0]);
      nf += int'(ft[1][0]);
      both |= rt[1][0] & ft[1][0];
    end
    chk("f1_rises", 1, 32'(nr), 3);
    chk("f1_falls", 1, 32'(nf), 3);
    chk("f1_overlap", 1, 32'(both), 0);

    // Reset mid-filter, then release with the level held high.
    cyc(6);
    level[3] = 1'b1;
    cyc(2);
    reset_n = 1'b0;
    #1;
    chk("rst_filt_out", 0, 32'({lf[0], rt[0], ft[0], ef[0], irq[0]}), 0);
    cyc(2);
    reset_n = 1'b1;
    cnt = 0;
    while (!rt[0][3] && cnt < 30) begin
      cyc();
      cnt++;
    end
    chk("rst_release_latency", 0, 32'(cnt), 32'(LAT0));
    reset_n = 1'b0;   // abort while in RISE
    #1;
    chk("rst_rise_out", 0, 32'({lf[0], rt[0], ft[0], ef[0], irq[0]}), 0);
    cyc(2);
    reset_n = 1'b1;

    // Randomised traffic, checked by the every-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5, 0) == 0) level[i] = ~level[i];
      if ((n % 64) == 0) mode = 8'($urandom);
      evt_clr = 4'($urandom & $urandom & $urandom);
      if (n == 1500) reset_n = 1'b0;
      if (n == 1502) reset_n = 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
